mdma_h2c_axis_sink: RTL and testbench



---
 rtl/mdma_h2c_axis_sink_pkg.sv | 18 +
 rtl/mdma_h2c_bp_gen.sv | 31 +++
 rtl/mdma_h2c_axis_sink.sv | 124 ++++++++++++
 tb/tb_mdma_h2c_axis_sink.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdma_h2c_axis_sink_pkg.sv
// Shared mdma defines: H2C sink error-bit positions, lane width and checker state encoding.
package mdma_h2c_axis_sink_pkg;

    localparam int H2C_LANE_W = 16;

    typedef enum logic [1:0] {
        ERR_PAT = 2'd0,
        ERR_QID = 2'd1,
        ERR_DMA = 2'd2,
        ERR_MTY = 2'd3
    } h2c_err_bit_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MID  = 1'b1
    } h2c_state_e;

endpackage

// File: rtl/mdma_h2c_bp_gen.sv
// Programmable backpressure: drops the ready mask for one cycle out of every bp_period.
module mdma_h2c_bp_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bp_period,
    output logic       ready_mask
);

    logic [3:0] cnt;
    logic [3:0] period_q;
    logic       run;

    // period_q lags bp_period by a cycle so any change restarts the count from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            period_q <= '0;
            run      <= 1'b0;
        end else begin
            run      <= 1'b1;
            period_q <= bp_period;
            if (bp_period != period_q || period_q == 4'd0 || cnt == period_q - 4'd1)
                cnt <= '0;
            else
                cnt <= cnt + 4'd1;
        end
    end

    assign ready_mask = run && !(period_q != 4'd0 && cnt == period_q - 4'd1);

endmodule

// File: rtl/mdma_h2c_axis_sink.sv
// H2C AXI-Stream sink: checks the incrementing lane pattern and QID per packet,
// keeps packet/byte statistics and latches the first error for readback.
//   state   | meaning
//   ST_IDLE | expecting beat 0 of a new packet
//   ST_MID  | inside a packet, beat_q holds the index of the next beat
module mdma_h2c_axis_sink
    import mdma_h2c_axis_sink_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int QID_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] h2c_tdata,
    input  logic              h2c_tvalid,
    output logic              h2c_tready,
    input  logic              h2c_tlast,
    input  logic [5:0]        h2c_mty,
    input  logic [QID_W-1:0]  h2c_qid,
    input  logic              h2c_zero_byte,
    input  logic              h2c_err,
    input  logic [3:0]        bp_period,
    input  logic              stat_clr,
    output logic [31:0]       pkt_cnt,
    output logic [47:0]       byte_cnt,
    output logic [3:0]        err_vec,
    output logic [QID_W-1:0]  err_qid,
    output logic [15:0]       err_beat
);

    localparam int LANES = DATA_W / H2C_LANE_W;
    localparam int BYTES = DATA_W / 8;

    h2c_state_e       state;
    logic [QID_W-1:0] qid_q;
    logic [15:0]      beat_q;
    logic [15:0]      base_q;
    logic [31:0]      acc_q;

    logic             hs;
    logic [15:0]      cur_beat;
    logic [15:0]      cur_base;
    logic [31:0]      cur_acc;
    logic [31:0]      pkt_bytes;
    logic [6:0]       nbytes;
    logic             pat_err;
    logic [3:0]       err_now;

    mdma_h2c_bp_gen u_bp_gen (
        .clk        (clk),
        .rst        (rst),
        .bp_period  (bp_period),
        .ready_mask (h2c_tready)
    );

    assign hs        = h2c_tvalid && h2c_tready;
    assign cur_beat  = (state == ST_IDLE) ? 16'd0 : beat_q;
    assign cur_base  = (state == ST_IDLE) ? 16'd0 : base_q;
    assign cur_acc   = (state == ST_IDLE) ? 32'd0 : acc_q;
    assign nbytes    = 7'(BYTES) - {1'b0, h2c_mty};
    assign pkt_bytes = h2c_zero_byte ? 32'd0 : cur_acc + 32'(nbytes);

    // On the last beat a lane straddling the valid boundary checks only its low byte
    always_comb begin
        pat_err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!h2c_tlast || (2 * i + 1) < int'(nbytes)) begin
                if (h2c_tdata[i*H2C_LANE_W +: H2C_LANE_W] != cur_base + 16'(i))
                    pat_err = 1'b1;
            end else if ((2 * i) < int'(nbytes)) begin
                if (h2c_tdata[i*H2C_LANE_W +: 8] != 8'(cur_base + 16'(i)))
                    pat_err = 1'b1;
            end
        end
        if (h2c_tlast && h2c_zero_byte)
            pat_err = 1'b0;
    end

    always_comb begin
        err_now          = '0;
        err_now[ERR_PAT] = pat_err;
        err_now[ERR_QID] = (state == ST_MID) && (h2c_qid != qid_q);
        err_now[ERR_DMA] = h2c_err;
        err_now[ERR_MTY] = h2c_zero_byte && h2c_tlast && (h2c_mty != 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            qid_q  <= '0;
            beat_q <= '0;
            base_q <= '0;
            acc_q  <= '0;
        end else if (hs) begin
            base_q <= cur_base + 16'(LANES);
            acc_q  <= cur_acc + 32'(BYTES);
            beat_q <= (cur_beat == 16'hFFFF) ? cur_beat : cur_beat + 16'd1;
            if (state == ST_IDLE)
                qid_q <= h2c_qid;
            state <= h2c_tlast ? ST_IDLE : ST_MID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            err_vec  <= '0;
            err_qid  <= '0;
            err_beat <= '0;
        end else if (hs) begin
            if (h2c_tlast) begin
                pkt_cnt  <= pkt_cnt + 32'd1;
                byte_cnt <= byte_cnt + {16'd0, pkt_bytes};
            end
            err_vec <= err_vec | err_now;
            if (err_vec == 4'd0 && err_now != 4'd0) begin
                err_qid  <= h2c_qid;
                err_beat <= cur_beat;
            end
        end
    end

endmodule

// File: tb/tb_mdma_h2c_axis_sink.sv
// Scenario bench for mdma_h2c_axis_sink with directed packets and a randomized packet model.
module tb_mdma_h2c_axis_sink;

    localparam int DATA_W = 512;
    localparam int QID_W  = 11;
    localparam int LANES  = DATA_W / 16;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] h2c_tdata = '0;
    logic              h2c_tvalid = 1'b0;
    logic              h2c_tready;
    logic              h2c_tlast = 1'b0;
    logic [5:0]        h2c_mty = '0;
    logic [QID_W-1:0]  h2c_qid = '0;
    logic              h2c_zero_byte = 1'b0;
    logic              h2c_err = 1'b0;
    logic [3:0]        bp_period = '0;
    logic              stat_clr = 1'b0;
    logic [31:0]       pkt_cnt;
    logic [47:0]       byte_cnt;
    logic [3:0]        err_vec;
    logic [QID_W-1:0]  err_qid;
    logic [15:0]       err_beat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdma_h2c_axis_sink #(.DATA_W(DATA_W), .QID_W(QID_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .h2c_tdata     (h2c_tdata),
        .h2c_tvalid    (h2c_tvalid),
        .h2c_tready    (h2c_tready),
        .h2c_tlast     (h2c_tlast),
        .h2c_mty       (h2c_mty),
        .h2c_qid       (h2c_qid),
        .h2c_zero_byte (h2c_zero_byte),
        .h2c_err       (h2c_err),
        .bp_period     (bp_period),
        .stat_clr      (stat_clr),
        .pkt_cnt       (pkt_cnt),
        .byte_cnt      (byte_cnt),
        .err_vec       (err_vec),
        .err_qid       (err_qid),
        .err_beat      (err_beat)
    );

    // Beat k of the reference pattern; bytes at or above nvalid are random filler
    function automatic logic [DATA_W-1:0] make_beat(int k, int nvalid);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < LANES; i++)
            d[i*16 +: 16] = 16'((k * LANES + i) % 65536);
        for (int b = nvalid; b < BYTES; b++)
            d[b*8 +: 8] = 8'($urandom);
        return d;
    endfunction

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input logic [5:0] mty,
                             input logic [QID_W-1:0] qid, input logic zb, input logic err,
                             input logic clr);
        int guard = 0;
        h2c_tdata     = d;
        h2c_tlast     = last;
        h2c_mty       = mty;
        h2c_qid       = qid;
        h2c_zero_byte = zb;
        h2c_err       = err;
        h2c_tvalid    = 1'b1;
        while (h2c_tready !== 1'b1 && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 64) begin
            checks++; failures++;
            $display("FAIL handshake_timeout tready=%b want 1", h2c_tready);
        end
        stat_clr = clr;
        @(posedge clk); #1;
        stat_clr   = 1'b0;
        h2c_tvalid = 1'b0;
        h2c_err    = 1'b0;
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (h2c_tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b want=0", h2c_tready); end
        checks++; if (pkt_cnt !== 32'd0) begin failures++; $display("FAIL rst_pkt_cnt got=%0d want=0", pkt_cnt); end
        checks++; if (byte_cnt !== 48'd0) begin failures++; $display("FAIL rst_byte_cnt got=%0d want=0", byte_cnt); end
        checks++; if (err_vec !== 4'd0) begin failures++; $display("FAIL rst_err_vec got=%b want=0000", err_vec); end
        checks++; if (err_qid !== '0 || err_beat !== 16'd0) begin failures++; $display("FAIL rst_err_capture got qid=%0d beat=%0d want 0/0", err_qid, err_beat); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (h2c_tready !== 1'b1) begin failures++; $display("FAIL rst_release_tready got=%b want=1", h2c_tready); end
    endtask

    task automatic test_clean_packet();
        pulse_clr();
        send_beat(make_beat(0, BYTES), 1'b0, 6'd0, 11'd5, 1'b0, 1'b0, 1'b0);
        send_beat(make_beat(1, BYTES), 1'b0, 6'd0, 11'd5, 1'b0, 1'b0, 1'b0);
        send_beat(make_beat(2, BYTES - 10), 1'b1, 6'd10, 11'd5, 1'b0, 1'b0, 1'b0);
        checks++; if (pkt_cnt !== 32'd1) begin failures++; $display("FAIL clean_pkt_cnt got=%0d want=1", pkt_cnt); end
        checks++; if (byte_cnt !== 48'd182) begin failures++; $display("FAIL clean_byte_cnt got=%0d want=182", byte_cnt); end
        checks++; if (err_vec !== 4'd0) begin failures++; $display("FAIL clean_err_vec got=%b want=0000", err_vec); end
    endtask

    task automatic test_pattern_err();
        logic [DATA_W-1:0] d;
        pulse_clr();
        send_beat(make_beat(0, BYTES), 1'b0, 6'd0, 11'd5, 1'b0, 1'b0, 1'b0);
        checks++; if (err_vec !== 4'd0) begin failures++; $display("FAIL pat_before got=%b want=0000", err_vec); end
        d = make_beat(1, BYTES);
        d[7*16 +: 16] = 16'hDEAD;
        send_beat(d, 1'b0, 6'd0, 11'd5, 1'b0, 1'b0, 1'b0);
        checks++; if (err_vec !== 4'b0001) begin failures++; $display("FAIL pat_err_vec got=%b want=0001", err_vec); end
        checks++; if (err_qid !== 11'd5 || err_beat !== 16'd1) begin failures++; $display("FAIL pat_capture got qid=%0d beat=%0d want 5/1", err_qid, err_beat); end
        send_beat(make_beat(2, BYTES - 10), 1'b1, 6'd10, 11'd5, 1'b0, 1'b0, 1'b0);
        send_beat(make_beat(0, BYTES), 1'b0, 6'd0, 11'd9, 1'b0, 1'b0, 1'b0);
        send_beat(make_beat(1, BYTES), 1'b1, 6'd0, 11'd9, 1'b0, 1'b0, 1'b0);
        checks++; if (err_vec !== 4'b0001 || err_qid !== 11'd5 || err_beat !== 16'd1) begin
            failures++; $display("FAIL pat_sticky got vec=%b qid=%0d beat=%0d want 0001/5/1", err_vec, err_qid, err_beat);
        end
    endtask

    task automatic test_qid_chg();
        pulse_clr();
        send_beat(make_beat(0, BYTES), 1'b0, 6'd0, 11'd5, 1'b0, 1'b0, 1'b0);
        send_beat(make_beat(1, BYTES), 1'b1, 6'd0, 11'd6, 1'b0, 1'b0, 1'b0);
        checks++; if (err_vec !== 4'b0010) begin failures++; $display("FAIL qid_err_vec got=%b want=0010", err_vec); end
        checks++; if (err_qid !== 11'd6 || err_beat !== 16'd1) begin failures++; $display("FAIL qid_capture got qid=%0d beat=%0d want 6/1", err_qid, err_beat); end
    endtask

    task automatic test_zero_byte();
        pulse_clr();
        send_beat({DATA_W{1'b1}}, 1'b1, 6'd0, 11'd2, 1'b1, 1'b0, 1'b0);
        checks++; if (pkt_cnt !== 32'd1 || byte_cnt !== 48'd0) begin failures++; $display("FAIL zb_counts got pkt=%0d bytes=%0d want 1/0", pkt_cnt, byte_cnt); end
        checks++; if (err_vec !== 4'd0) begin failures++; $display("FAIL zb_no_err got=%b want=0000", err_vec); end
        send_beat({DATA_W{1'b1}}, 1'b1, 6'd3, 11'd2, 1'b1, 1'b0, 1'b0);
        checks++; if (err_vec !== 4'b1000) begin failures++; $display("FAIL zb_mty_err got=%b want=1000", err_vec); end
        checks++; if (pkt_cnt !== 32'd2 || byte_cnt !== 48'd0) begin failures++; $display("FAIL zb_counts2 got pkt=%0d bytes=%0d want 2/0", pkt_cnt, byte_cnt); end
    endtask

    task automatic test_throttle();
        logic rec [0:399];
        int   n = 0;
        int   nhs = 0;
        int   first = -1;
        int   bad = 0;
        logic streaming = 1'b1;
        pulse_clr();
        bp_period = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    for (int k = 0; k < 4; k++)
                        send_beat(make_beat(k, BYTES), k == 3, 6'd0, 11'd9, 1'b0, 1'b0,
                                  (p == 24) && (k == 3));
                    if (p == 23) begin
                        checks++; if (pkt_cnt !== 32'd24 || byte_cnt !== 48'd6144) begin
                            failures++; $display("FAIL bp_counts got pkt=%0d bytes=%0d want 24/6144", pkt_cnt, byte_cnt);
                        end
                    end
                end
                streaming = 1'b0;
            end
            begin
                while (streaming && n < 400) begin
                    @(negedge clk);
                    if (streaming) begin
                        rec[n] = h2c_tready;
                        if (h2c_tvalid && h2c_tready) nhs++;
                        n++;
                    end
                end
            end
        join
        for (int i = 0; i < n; i++)
            if (first < 0 && rec[i] == 1'b0) first = i;
        for (int i = 0; i < n; i++)
            if (rec[i] !== ((first >= 0 && i >= first && (i - first) % 4 == 0) ? 1'b0 : 1'b1)) bad++;
        checks++; if (first < 0 || first > 3 || bad != 0) begin failures++; $display("FAIL bp_pattern got first_low=%0d bad_cycles=%0d want first_low<4 bad_cycles=0", first, bad); end
        checks++; if (nhs != 100) begin failures++; $display("FAIL bp_handshakes got=%0d want=100", nhs); end
        checks++; if (pkt_cnt !== 32'd0 || byte_cnt !== 48'd0 || err_vec !== 4'd0) begin
            failures++; $display("FAIL bp_clr_on_last got pkt=%0d bytes=%0d err=%b want 0/0/0000", pkt_cnt, byte_cnt, err_vec);
        end
        bp_period = 4'd0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        send_beat(make_beat(0, BYTES), 1'b0, 6'd0, 11'd3, 1'b0, 1'b0, 1'b0);
        send_beat(make_beat(1, BYTES), 1'b0, 6'd0, 11'd3, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_beat(make_beat(0, BYTES), 1'b1, 6'd0, 11'd4, 1'b0, 1'b0, 1'b0);
        checks++; if (err_vec !== 4'd0) begin failures++; $display("FAIL rstmid_err got=%b want=0000", err_vec); end
        checks++; if (pkt_cnt !== 32'd1 || byte_cnt !== 48'd64) begin failures++; $display("FAIL rstmid_counts got pkt=%0d bytes=%0d want 1/64", pkt_cnt, byte_cnt); end
    endtask

    // Packet-level model: injected faults map directly to the flags they must raise
    task automatic test_random();
        logic [3:0]       e_vec = '0;
        logic [QID_W-1:0] e_qid = '0;
        logic [15:0]      e_beat = '0;
        int unsigned      e_pkt = 0;
        longint unsigned  e_bytes = 0;
        pulse_clr();
        for (int p = 0; p < 40; p++) begin
            int nb = $urandom_range(1, 4);
            int mty = $urandom_range(0, 63);
            int kind = $urandom_range(0, 9);
            int kk;
            logic [QID_W-1:0] q = QID_W'($urandom);
            if (p % 10 == 0) begin
                pulse_clr();
                e_vec = '0; e_qid = '0; e_beat = '0; e_pkt = 0; e_bytes = 0;
            end
            case ($urandom_range(0, 4))
                0, 1:    bp_period = 4'd0;
                2:       bp_period = 4'd2;
                3:       bp_period = 4'd3;
                default: bp_period = 4'd7;
            endcase
            if (kind == 3 || kind == 4) nb = 1;
            if (kind == 3 && mty == 0) mty = 1;
            if (kind == 4) mty = 0;
            kk = $urandom_range(0, nb - 1);
            for (int k = 0; k < nb; k++) begin
                logic              last = (k == nb - 1);
                logic              zb = last && (kind == 3 || kind == 4);
                logic [5:0]        m = last ? 6'(mty) : 6'($urandom);
                logic [QID_W-1:0]  qq = (kind == 1 && k == 1) ? (q ^ QID_W'(1)) : q;
                logic              er = (kind == 2) && last;
                logic [3:0]        flags;
                logic [DATA_W-1:0] d = zb ? {16{$urandom}} : make_beat(k, last ? BYTES - mty : BYTES);
                if (kind == 0 && k == kk) d[7:0] = d[7:0] ^ 8'h01;
                flags = {kind == 3, er, kind == 1 && k == 1, kind == 0 && k == kk};
                send_beat(d, last, m, qq, zb, er, 1'b0);
                if (e_vec == 4'd0 && flags != 4'd0) begin
                    e_qid  = qq;
                    e_beat = 16'(k);
                end
                e_vec = e_vec | flags;
                checks++; if (err_vec !== e_vec) begin failures++; $display("FAIL rnd_err_vec pkt=%0d beat=%0d got=%b want=%b", p, k, err_vec, e_vec); end
                checks++; if (err_qid !== e_qid || err_beat !== e_beat) begin
                    failures++; $display("FAIL rnd_capture pkt=%0d got qid=%0d beat=%0d want %0d/%0d", p, err_qid, err_beat, e_qid, e_beat);
                end
            end
            e_pkt++;
            if (!(kind == 3 || kind == 4)) e_bytes += longint'((nb - 1) * BYTES + BYTES - mty);
            checks++; if (pkt_cnt !== 32'(e_pkt)) begin failures++; $display("FAIL rnd_pkt_cnt pkt=%0d got=%0d want=%0d", p, pkt_cnt, e_pkt); end
            checks++; if (byte_cnt !== 48'(e_bytes)) begin failures++; $display("FAIL rnd_byte_cnt pkt=%0d got=%0d want=%0d", p, byte_cnt, e_bytes); end
        end
        bp_period = 4'd0;
    endtask

    initial begin
        test_reset();
        test_clean_packet();
        test_pattern_err();
        test_qid_chg();
        test_zero_byte();
        test_throttle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
